// File: rtl/chip8_ps2_keypad.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_ps2_keypad
//  Description : PS/2 keyboard receiver that maps set-2 scancodes onto the
//                16-key CHIP-8 hex keypad and holds the key state.
//  Revision    : 1.0  initial release
// ============================================================================
module chip8_ps2_keypad #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [15:0] keys,
    output logic        any_key,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        key_pressed,
    output logic        frame_err
);

    localparam int FW = (FILTER  > 1) ? $clog2(FILTER + 1)  : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic [1:0]    state, state_next;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] idle_cnt;
    logic [10:0]   frame_sr;
    logic          frame_ok, timeout_hit, byte_accept;
    logic          ext_flag, brk_flag;
    logic [7:0]    rx_byte;
    logic [4:0]    map_res;

    // Set-2 scancode to CHIP-8 key lookup; bit 4 flags a mapped code
    function automatic logic [4:0] map_scan(input logic [7:0] sc);
        case (sc)
            8'h16: map_scan = 5'h11;
            8'h1E: map_scan = 5'h12;
            8'h26: map_scan = 5'h13;
            8'h25: map_scan = 5'h1C;
            8'h15: map_scan = 5'h14;
            8'h1D: map_scan = 5'h15;
            8'h24: map_scan = 5'h16;
            8'h2D: map_scan = 5'h1D;
            8'h1C: map_scan = 5'h17;
            8'h1B: map_scan = 5'h18;
            8'h23: map_scan = 5'h19;
            8'h2B: map_scan = 5'h1E;
            8'h1A: map_scan = 5'h1A;
            8'h22: map_scan = 5'h10;
            8'h21: map_scan = 5'h1B;
            8'h2A: map_scan = 5'h1F;
            default: map_scan = 5'h00;
        endcase
    endfunction

    // Two-flop synchronizers for the asynchronous PS/2 lines (idle high)
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'b1111;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: a new ps2_clk level must persist FILTER samples
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall    = clk_filt_d & ~clk_filt;
    assign rx_byte = frame_sr[8:1];
    assign map_res = map_scan(rx_byte);

    // Receiver state register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Receiver next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fall) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (fall && bit_cnt == 4'd10) state_next = ST_CHECK;
                else if (timeout_hit)         state_next = ST_IDLE;
            end
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Receiver outputs: framing verdict, timeout and error pulse
    always_comb begin
        frame_ok    = ~frame_sr[0] & frame_sr[10] & (^frame_sr[9:1]);
        timeout_hit = (state == ST_SHIFT) && !fall && (idle_cnt == IDLE_LAST);
        byte_accept = (state == ST_CHECK) && frame_ok;
        frame_err   = ((state == ST_CHECK) && !frame_ok) || timeout_hit;
    end

    // Bit shifter, bit counter and saturating idle counter
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            frame_sr <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            if (fall && state != ST_CHECK) frame_sr <= {dat_s2, frame_sr[10:1]};

            if (state == ST_IDLE && fall)                          bit_cnt <= 4'd1;
            else if (state == ST_SHIFT && fall)                    bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
            else if (timeout_hit || state == ST_CHECK)             bit_cnt <= 4'd0;

            if (state != ST_SHIFT || fall)  idle_cnt <= '0;
            else if (idle_cnt != IDLE_LAST) idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Scancode decoder: prefix flags, key map and event outputs
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            keys        <= '0;
            key_event   <= 1'b0;
            key_code    <= '0;
            key_pressed <= 1'b0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_accept) begin
                if (rx_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (!ext_flag && map_res[4]) begin
                        keys[map_res[3:0]] <= ~brk_flag;
                        key_code           <= map_res[3:0];
                        key_pressed        <= ~brk_flag;
                        key_event          <= 1'b1;
                    end
                end
            end
        end
    end

    assign any_key = |keys;

endmodule
`default_nettype wire

// File: tb/tb_chip8_ps2_keypad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chip8_ps2_keypad
//  Description : Directed, table-driven self-checking bench for the PS/2
//                CHIP-8 keypad decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_chip8_ps2_keypad;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 500;
    localparam int HALF    = 30;
    localparam int NVEC    = 21;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [15:0] keys;
    logic        any_key, key_event, key_pressed, frame_err;
    logic [3:0]  key_code;

    chip8_ps2_keypad #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .keys        (keys),
        .any_key     (any_key),
        .key_event   (key_event),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .frame_err   (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  data;
        bit          flip;
        int          ev;
        int          err;
        logic [15:0] keys;
        logic [3:0]  code;
        logic        pressed;
    } vec_t;

    vec_t tbl [NVEC];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ev_cnt = 0, ev_cyc = 0;
    int err_cnt = 0, err_cyc = 0;
    int both_cnt = 0;
    int last_drop = 0;

    // Free-running cycle count
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Record output pulses away from the active edge
    always @(negedge clk_sys) begin
        if (key_event) begin
            ev_cnt <= ev_cnt + 1;
            ev_cyc <= cyc;
        end
        if (frame_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (key_event && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_sys);
        ps2_dat = b;
        repeat (10) @(negedge clk_sys);
        ps2_clk = 1'b0;
        last_drop = cyc;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (HALF - 10) @(negedge clk_sys);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^d) ^ flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic chk_state(input string tag, input logic [15:0] k, input logic [3:0] c, input logic p);
        chk({tag, ".keys"}, 32'(keys), 32'(k));
        chk({tag, ".any_key"}, 32'(any_key), 32'(k != 16'h0));
        chk({tag, ".key_code"}, 32'(key_code), 32'(c));
        chk({tag, ".key_pressed"}, 32'(key_pressed), 32'(p));
    endtask

    initial begin
        int ev0, err0;
        tbl[0]  = '{8'h1C, 0, 1, 0, 16'h0080, 4'h7, 1'b1};
        tbl[1]  = '{8'hF0, 0, 0, 0, 16'h0080, 4'h7, 1'b1};
        tbl[2]  = '{8'h1C, 0, 1, 0, 16'h0000, 4'h7, 1'b0};
        tbl[3]  = '{8'hE0, 0, 0, 0, 16'h0000, 4'h7, 1'b0};
        tbl[4]  = '{8'h1C, 0, 0, 0, 16'h0000, 4'h7, 1'b0};
        tbl[5]  = '{8'h1C, 0, 1, 0, 16'h0080, 4'h7, 1'b1};
        tbl[6]  = '{8'h22, 1, 0, 1, 16'h0080, 4'h7, 1'b1};
        tbl[7]  = '{8'h22, 0, 1, 0, 16'h0081, 4'h0, 1'b1};
        tbl[8]  = '{8'h22, 0, 1, 0, 16'h0081, 4'h0, 1'b1};
        tbl[9]  = '{8'hF0, 0, 0, 0, 16'h0081, 4'h0, 1'b1};
        tbl[10] = '{8'h25, 0, 1, 0, 16'h0081, 4'hC, 1'b0};
        tbl[11] = '{8'h55, 0, 0, 0, 16'h0081, 4'hC, 1'b0};
        tbl[12] = '{8'hF0, 0, 0, 0, 16'h0081, 4'hC, 1'b0};
        tbl[13] = '{8'h22, 0, 1, 0, 16'h0080, 4'h0, 1'b0};
        tbl[14] = '{8'hE0, 0, 0, 0, 16'h0080, 4'h0, 1'b0};
        tbl[15] = '{8'hF0, 0, 0, 0, 16'h0080, 4'h0, 1'b0};
        tbl[16] = '{8'h1C, 0, 0, 0, 16'h0080, 4'h0, 1'b0};
        tbl[17] = '{8'hF0, 0, 0, 0, 16'h0080, 4'h0, 1'b0};
        tbl[18] = '{8'h1C, 1, 0, 1, 16'h0080, 4'h0, 1'b0};
        tbl[19] = '{8'h1C, 0, 1, 0, 16'h0080, 4'h7, 1'b1};
        tbl[20] = '{8'h2B, 0, 1, 0, 16'h4080, 4'hE, 1'b1};

        // Reset state
        repeat (5) @(negedge clk_sys);
        chk_state("reset", 16'h0000, 4'h0, 1'b0);
        chk("reset.key_event", 32'(key_event), 32'd0);
        chk("reset.frame_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);

        // Table-driven frames
        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            ev0 = ev_cnt;
            err0 = err_cnt;
            send_frame(tbl[i].data, tbl[i].flip, 11);
            chk({tag, ".events"}, 32'(ev_cnt - ev0), 32'(tbl[i].ev));
            chk({tag, ".errors"}, 32'(err_cnt - err0), 32'(tbl[i].err));
            if (tbl[i].ev == 1)  chk({tag, ".ev_latency"}, 32'(ev_cyc - last_drop), 32'(FILTER + 4));
            if (tbl[i].err == 1) chk({tag, ".err_latency"}, 32'(err_cyc - last_drop), 32'(FILTER + 3));
            chk_state(tag, tbl[i].keys, tbl[i].code, tbl[i].pressed);
        end

        // Partial frame abandoned after TIMEOUT idle cycles
        ev0 = ev_cnt;
        err0 = err_cnt;
        send_frame(8'h2A, 0, 5);
        repeat (TIMEOUT + 100) @(negedge clk_sys);
        chk("timeout.errors", 32'(err_cnt - err0), 32'd1);
        chk("timeout.latency", 32'(err_cyc - last_drop), 32'(FILTER + 2 + TIMEOUT));
        chk("timeout.events", 32'(ev_cnt - ev0), 32'd0);
        send_frame(8'h2A, 0, 11);
        chk("after_timeout.events", 32'(ev_cnt - ev0), 32'd1);
        chk_state("after_timeout", 16'hC080, 4'hF, 1'b1);

        // Short glitch on ps2_clk while idle must not start a frame
        ev0 = ev_cnt;
        err0 = err_cnt;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (TIMEOUT + 50) @(negedge clk_sys);
        chk("glitch.errors", 32'(err_cnt - err0), 32'd0);

        // Reset mid-frame, then a clean frame
        send_frame(8'h16, 0, 6);
        reset_n = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk_state("midreset", 16'h0000, 4'h0, 1'b0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        ev0 = ev_cnt;
        err0 = err_cnt;
        send_frame(8'h16, 0, 11);
        chk("post_reset.events", 32'(ev_cnt - ev0), 32'd1);
        chk("post_reset.errors", 32'(err_cnt - err0), 32'd0);
        chk("post_reset.ev_latency", 32'(ev_cyc - last_drop), 32'(FILTER + 4));
        chk_state("post_reset", 16'h0002, 4'h1, 1'b1);

        chk("event_err_overlap", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chip8_ps2_keypad.md
CHIP8_PS2_KEYPAD -- requirements
Module: chip8_ps2_keypad

Interface
REQ-001 SHALL have parameter FILTER, default 8: clk_sys cycles ps2_clk must hold a new level before it is accepted.
REQ-002 SHALL have parameter TIMEOUT, default 100000: clk_sys cycles without an accepted ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk_sys  in  1  system clock; the only clock.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 ps2_clk  in  1  PS/2 clock from keyboard source, asynchronous.
REQ-006 ps2_dat  in  1  PS/2 data from keyboard source, asynchronous.
REQ-007 keys  out  16  held state of CHIP-8 keys 0x0..0xF, 1 = pressed.
REQ-008 any_key  out  1  OR of keys.
REQ-009 key_event  out  1  one-cycle pulse on each mapped make or break code.
REQ-010 key_code  out  4  CHIP-8 key of last event; held until next event.
REQ-011 key_pressed  out  1  1 = last event was make, 0 = break; held.
REQ-012 frame_err  out  1  one-cycle pulse on a rejected or timed-out frame.

Function
REQ-013 SHALL pass ps2_clk and ps2_dat through 2-flop synchronizers before any use.
REQ-014 SHALL accept a new filtered ps2_clk level only after FILTER consecutive equal synchronized samples; glitches shorter than FILTER SHALL be ignored.
REQ-015 SHALL sample synchronized ps2_dat on each filtered ps2_clk 1->0 transition.
REQ-016 Receiver SHALL use states IDLE, SHIFT, CHECK: IDLE->SHIFT on first sampled bit; SHIFT holds a 4-bit count 0..10; SHIFT->CHECK after the 11th bit; CHECK->IDLE after one cycle.
REQ-017 Frame SHALL be start(0), 8 data bits LSB first, odd parity, stop(1); CHECK SHALL accept the byte only if all three framing conditions hold.
REQ-018 Failed check SHALL pulse frame_err in the CHECK cycle, discard the byte, and clear the break and extended prefix flags.
REQ-019 In SHIFT, TIMEOUT cycles without a falling edge SHALL return to IDLE, zero the bit count, pulse frame_err once, and clear prefix flags; the idle counter SHALL reset on every accepted falling edge and saturate, never wrap.
REQ-020 Accepted byte 0xE0 SHALL set the extended flag; 0xF0 SHALL set the break flag; neither produces key_event.
REQ-021 Other accepted byte SHALL clear both flags after use; it SHALL update the key map only if the extended flag was clear and the byte is mapped.
REQ-022 Map (set 2 scancode -> key): 16->1, 1E->2, 26->3, 25->C, 15->4, 1D->5, 24->6, 2D->D, 1C->7, 1B->8, 23->9, 2B->E, 1A->A, 22->0, 21->B, 2A->F; all other bytes unmapped and ignored.
REQ-023 Mapped byte SHALL set keys[k] = ~break flag, load key_code = k and key_pressed = ~break flag, and pulse key_event, all on the clk_sys edge following the CHECK cycle.
REQ-024 Repeated make codes (typematic) SHALL each pulse key_event; keys[k] stays 1.
REQ-025 Break of a key not pressed SHALL pulse key_event with key_pressed = 0; keys unchanged.
REQ-026 Latency: key_event SHALL assert exactly 2 clk_sys cycles after the filtered falling edge that samples the stop bit.
REQ-027 key_event and frame_err SHALL never assert in the same cycle.
REQ-028 any_key SHALL be combinational from keys (no added latency).

Reset
REQ-029 With reset_n low at a clk_sys edge: keys=0, any_key=0, key_event=0, key_code=0, key_pressed=0, frame_err=0, receiver IDLE, bit count 0, prefix flags clear, filter and timeout counters 0, filtered ps2_clk=1.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first frame after reset_n rises SHALL decode normally.

Verification
REQ-031 Frame 0x1C (parity 0... odd -> parity bit 0), 20 us bit period -> key_event, key_code=7, key_pressed=1, keys=0x0080, any_key=1, 2 cycles after stop-bit edge.
REQ-032 Frames F0,1C after REQ-031 -> one key_event, key_code=7, key_pressed=0, keys=0x0000; no event on F0.
REQ-033 Frames E0,1C -> no key_event, keys unchanged; following 1C -> key 7 pressed.
REQ-034 Frame 0x22 with parity bit inverted -> frame_err pulse, no key_event, keys unchanged; next valid 0x22 -> keys=0x0001.
REQ-035 Send 5 bits then stop ps2_clk high -> frame_err exactly TIMEOUT cycles after last edge; next full frame 0x2A -> keys bit 15 set.
REQ-036 3-cycle low glitch on ps2_clk in IDLE -> no bit sampled; reset_n low after 6 bits then valid 0x16 -> keys=0x0002.
